// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and default constants for the mem_responder block.
//   state_t         : responder FSM states (IDLE, READ_WAIT)
//   DEF_ADDR_W      : default address width
//   DEF_DATA_W      : default data width
//   DEF_PROT_LIMIT  : default write-protect boundary (addresses below it are
//                     protected when MEM_RESP_PROTECT_EN is defined)
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  localparam int          DEF_ADDR_W     = 16;
  localparam int          DEF_DATA_W     = 16;
  localparam int unsigned DEF_PROT_LIMIT = 32'h0000_0100;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } state_t;

endpackage : mem_resp_pkg

// File: rtl/mem_resp_array.sv
// -----------------------------------------------------------------------------
// mem_resp_array
// Single-clock word storage with one synchronous write port and one
// synchronous read port. The read port output register is the responder's
// DataOut: it loads only on a read and otherwise holds its value.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high, clears the read data register only
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable
//   raddr  : read address
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  // NOTE: the storage array has no reset; contents must survive Reset, and a
  // reset loop over every word would not map onto RAM macros anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : mem_resp_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Processor-facing memory responder with configurable read latency.
//
// Timing: a read sampled at edge k loads DataOut at edge k+READ_LAT-1, so
// Valid is high during the cycle that ends at edge k+READ_LAT. Busy is high
// for the READ_LAT-1 cycles in between, and a new request may be issued in
// the Valid cycle, giving one read per READ_LAT cycles back-to-back.
//
// Configuration macro: MEM_RESP_PROTECT_EN
//   defined   : writes to addresses below PROT_LIMIT are dropped and pulse Err
//   undefined : every address is writable; Err only flags RD and WR together
//
// Parameters: ADDR_W, DATA_W, READ_LAT (1..4), PROT_LIMIT
// Ports:
//   Clk1    : clock, rising edge
//   Reset   : synchronous active-high reset (memory contents preserved)
//   Addr    : request address
//   RD, WR  : read / write request strobes, sampled at the rising edge
//   DataIn  : write data
//   DataOut : registered read data, holds between reads
//   Valid   : one-cycle pulse, DataOut carries new read data
//   Busy    : a read is outstanding; requests are ignored while high
//   Err     : one-cycle pulse, request rejected
// -----------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          DATA_W     = DEF_DATA_W,
  parameter int          READ_LAT   = 1,
  parameter int unsigned PROT_LIMIT = DEF_PROT_LIMIT
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Valid,
  output logic              Busy,
  output logic              Err
);

`ifdef MEM_RESP_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  // Wait cycles left after the capturing edge; zero means "read at next edge".
  localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
  logic              err_nxt;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_protected;

  assign wr_protected = PROT_ON && (32'(Addr) < PROT_LIMIT);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cap_addr_nxt = cap_addr;
    err_nxt      = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = Addr;

    unique case (state)
      IDLE: begin
        // Requests on a reset edge must not touch memory.
        if (!Reset) begin
          if (RD && WR) begin
            err_nxt = 1'b1;
          end else if (WR) begin
            if (wr_protected) begin
              err_nxt = 1'b1;
            end else begin
              wr_en = 1'b1;
            end
          end else if (RD) begin
            if (READ_LAT == 1) begin
              rd_en = 1'b1;
            end else begin
              state_nxt    = READ_WAIT;
              cnt_nxt      = CNT_INIT;
              cap_addr_nxt = Addr;
            end
          end
        end
      end

      READ_WAIT: begin
        rd_addr = cap_addr;
        if (cnt == 2'd0) begin
          rd_en     = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      cap_addr <= '0;
      Valid    <= 1'b0;
      Err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cap_addr <= cap_addr_nxt;
      Valid    <= rd_en;
      Err      <= err_nxt;
    end
  end

  assign Busy = (state == READ_WAIT);

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (Clk1),
    .rst   (Reset),
    .we    (wr_en),
    .waddr (Addr),
    .wdata (DataIn),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (DataOut)
  );

endmodule : mem_responder
